// File: rtl/mfcc_ctrl_pkg.sv
// Shared definitions for the MFCC copy controllers: copy FSM state encoding and
// default timing/geometry constants.
package mfcc_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRdAddr = 3'd1,
    StRdWait = 3'd2,
    StWrite  = 3'd3,
    StNext   = 3'd4,
    StDone   = 3'd5
  } copy_state_e;

  localparam int unsigned DefaultRdLatency    = 3;
  localparam int unsigned DefaultWrCycles     = 2;
  localparam int unsigned DefaultResultStride = 13;

endpackage

// File: rtl/ctrl_down_counter.sv
// Loadable down-counter with terminal-count flag; saturates at zero.
module ctrl_down_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;

  // Load has priority over decrement; holds at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/energy_copy_ctrl.sv
// Copies one log-energy word per frame from the energy buffer RAM into the energy
// slot of each frame row in the MFCC result RAM.
// Optional feature: define ENERGY_COPY_FLOOR_EN to clamp captured words to ENERGY_FLOOR.
module energy_copy_ctrl
  import mfcc_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned FRAME_CNT_W   = 8,
  parameter int unsigned RD_LATENCY    = DefaultRdLatency,
  parameter int unsigned WR_CYCLES     = DefaultWrCycles,
  parameter int unsigned RESULT_STRIDE = DefaultResultStride,
  parameter int          ENERGY_FLOOR  = -32768
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [FRAME_CNT_W-1:0] num_frames,
  input  logic [ADDR_WIDTH-1:0]  rd_base,
  input  logic [ADDR_WIDTH-1:0]  wr_base,
  output logic                   rd_en,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   busy,
  output logic                   done,
  output logic [FRAME_CNT_W-1:0] frame_idx
);

  localparam int unsigned CntMax = (RD_LATENCY > WR_CYCLES) ? RD_LATENCY : WR_CYCLES;
  localparam int unsigned CntW   = (CntMax < 2) ? 1 : $clog2(CntMax + 1);
  localparam longint      FloorMin = -(longint'(1) <<< (DATA_WIDTH - 1));
  localparam longint      FloorMax = (longint'(1) <<< (DATA_WIDTH - 1)) - 1;

  // Parameter sanity checks at elaboration.
  if (RD_LATENCY < 1 || WR_CYCLES < 1) begin : g_bad_timing
    $error("energy_copy_ctrl: RD_LATENCY and WR_CYCLES must be at least 1");
  end
  if (longint'(ENERGY_FLOOR) < FloorMin || longint'(ENERGY_FLOOR) > FloorMax) begin : g_bad_floor
    $error("energy_copy_ctrl: ENERGY_FLOOR does not fit in DATA_WIDTH");
  end

  copy_state_e            state_q;
  logic [FRAME_CNT_W-1:0] num_frames_q;
  logic [FRAME_CNT_W-1:0] frame_idx_q;
  logic [ADDR_WIDTH-1:0]  rd_addr_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   rd_en_q;
  logic                   wr_en_q;
  logic                   busy_q;
  logic                   done_q;

  logic                   cnt_load;
  logic [CntW-1:0]        cnt_load_val;
  logic                   cnt_dec;
  logic                   cnt_tc;
  logic [DATA_WIDTH-1:0]  capture_val;

`ifdef ENERGY_COPY_FLOOR_EN
  assign capture_val = ($signed(rd_data) < ENERGY_FLOOR) ? DATA_WIDTH'(ENERGY_FLOOR) : rd_data;
`else
  assign capture_val = rd_data;
`endif

  // One counter serves both the read wait and the write hold; it is reloaded
  // for the write on the same cycle the read data is captured.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      StRdAddr: begin
        cnt_load     = 1'b1;
        cnt_load_val = CntW'(RD_LATENCY - 1);
      end
      StRdWait: begin
        if (cnt_tc) begin
          cnt_load     = 1'b1;
          cnt_load_val = CntW'(WR_CYCLES - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StWrite: cnt_dec = !cnt_tc;
      default: ;
    endcase
  end

  ctrl_down_counter #(
    .WIDTH (CntW)
  ) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  // Copy sequencer with registered strobes and address streams.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      num_frames_q <= '0;
      frame_idx_q  <= '0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      data_q       <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            num_frames_q <= num_frames;
            frame_idx_q  <= '0;
            rd_addr_q    <= rd_base;
            wr_addr_q    <= wr_base;
            busy_q       <= 1'b1;
            if (num_frames == '0) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              rd_en_q <= 1'b1;
              state_q <= StRdAddr;
            end
          end
        end
        StRdAddr: state_q <= StRdWait;
        StRdWait: begin
          if (cnt_tc) begin
            data_q  <= capture_val;
            wr_en_q <= 1'b1;
            state_q <= StWrite;
          end
        end
        StWrite: begin
          if (cnt_tc) begin
            wr_en_q <= 1'b0;
            state_q <= StNext;
          end
        end
        StNext: begin
          if (frame_idx_q == num_frames_q - FRAME_CNT_W'(1)) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            frame_idx_q <= frame_idx_q + FRAME_CNT_W'(1);
            rd_addr_q   <= rd_addr_q + ADDR_WIDTH'(1);
            wr_addr_q   <= wr_addr_q + ADDR_WIDTH'(RESULT_STRIDE);
            rd_en_q     <= 1'b1;
            state_q     <= StRdAddr;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_idx = frame_idx_q;

endmodule

// File: tb/tb_energy_copy_ctrl.sv
// Self-checking bench for energy_copy_ctrl: directed scenarios plus randomized
// jobs against a transaction-level model of the expected RAM traffic.
module tb_energy_copy_ctrl;

  localparam int AW          = 12;
  localparam int DW          = 16;
  localparam int FW          = 8;
  localparam int RL          = 3;
  localparam int WC          = 2;
  localparam int Stride      = 13;
  localparam int Floor       = -1000;
  localparam int FrameCycles = RL + WC + 2;
  localparam int MemWords    = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [FW-1:0] num_frames;
  logic [AW-1:0] rd_base;
  logic [AW-1:0] wr_base;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic [FW-1:0] frame_idx;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mem [MemWords];

  // Energy RAM model: data appears RL cycles after the read strobe.
  logic [RL-1:0] pipe_v = '0;
  logic [AW-1:0] pipe_a [RL];

  always @(posedge clk) begin
    pipe_v    <= {pipe_v[RL-2:0], rd_en};
    pipe_a[0] <= rd_addr;
    for (int i = 1; i < RL; i++) pipe_a[i] <= pipe_a[i-1];
  end

  assign rd_data = pipe_v[RL-1] ? mem[pipe_a[RL-1]] : 16'h5A5A;

  always #5 clk = ~clk;

  energy_copy_ctrl #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .FRAME_CNT_W   (FW),
    .RD_LATENCY    (RL),
    .WR_CYCLES     (WC),
    .RESULT_STRIDE (Stride),
    .ENERGY_FLOOR  (Floor)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_frames (num_frames),
    .rd_base    (rd_base),
    .wr_base    (wr_base),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .frame_idx  (frame_idx)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word the result RAM should receive for a given energy word.
  function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] v);
`ifdef ENERGY_COPY_FLOOR_EN
    if ($signed(v) < Floor) return DW'(Floor);
`endif
    return v;
  endfunction

  // mode 0: single start pulse; 1: start held until done; 2: extra pulse mid-run.
  task automatic run_job(input int nf, input int rb, input int wb, input int mode);
    int t, done_t, done_cnt, n_rd, n_wr, first_rd, overlap, busy_err, hold_err, grp_len;
    int exp_done, budget;
    logic prev_wr;
    logic [AW-1:0] grp_addr;
    logic [DW-1:0] grp_data;
    exp_done = 1 + nf * FrameCycles;
    budget   = exp_done + 40;
    t = 0; done_t = -1; done_cnt = 0; n_rd = 0; n_wr = 0; first_rd = -1;
    overlap = 0; busy_err = 0; hold_err = 0; grp_len = 0; prev_wr = 1'b0;
    grp_addr = '0; grp_data = '0;
    num_frames = FW'(nf);
    rd_base    = AW'(rb);
    wr_base    = AW'(wb);
    start      = 1'b1;
    while (t < budget && (done_t < 0 || t < done_t + 4)) begin
      @(negedge clk);
      t++;
      if (rd_en) begin
        if (first_rd < 0) first_rd = t;
        check_eq("rd_addr", rd_addr, (rb + n_rd) % MemWords);
        n_rd++;
      end
      if (rd_en && wr_en) overlap++;
      if (wr_en) begin
        if (!prev_wr) begin
          grp_addr = wr_addr;
          grp_data = wr_data;
          grp_len  = 1;
        end else begin
          grp_len++;
          if (wr_addr !== grp_addr || wr_data !== grp_data) hold_err++;
        end
      end else if (prev_wr) begin
        check_eq("wr_addr", grp_addr, (wb + n_wr * Stride) % MemWords);
        check_eq("wr_data", grp_data, exp_word(mem[(rb + n_wr) % MemWords]));
        check_eq("wr_len", grp_len, WC);
        check_eq("frame_idx", frame_idx, n_wr);
        n_wr++;
      end
      prev_wr = wr_en;
      if (done) begin
        done_cnt++;
        if (done_t < 0) done_t = t;
      end
      if (busy !== ((done_t < 0) || (t <= done_t))) busy_err++;
      start = (mode == 1 && done_t < 0) || (mode == 2 && nf > 0 && t == 3);
    end
    start = 1'b0;
    check_eq("done_cycle", done_t, exp_done);
    check_eq("done_count", done_cnt, 1);
    check_eq("rd_count", n_rd, nf);
    check_eq("wr_count", n_wr, nf);
    check_eq("rd_wr_overlap", overlap, 0);
    check_eq("busy_trace", busy_err, 0);
    check_eq("wr_hold", hold_err, 0);
    if (nf > 0) check_eq("first_rd_latency", first_rd, 1);
  endtask

  // Reset during the first write cycle of frame 1 must abort silently.
  task automatic run_abort();
    int acc;
    num_frames = FW'(3);
    rd_base    = AW'(12'h030);
    wr_base    = AW'(12'h300);
    start      = 1'b1;
    for (int t = 1; t <= 1 + FrameCycles + 1 + RL; t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check_eq("abort_in_write", {wr_en, frame_idx}, {1'b1, FW'(1)});
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_strobes", {busy, done, rd_en, wr_en}, 4'b0000);
    check_eq("abort_rd_addr", rd_addr, 0);
    check_eq("abort_wr_addr", wr_addr, 0);
    check_eq("abort_wr_data", wr_data, 0);
    check_eq("abort_frame_idx", frame_idx, 0);
    rst = 1'b0;
    acc = 0;
    repeat (12) begin
      @(negedge clk);
      if (rd_en || wr_en || done || busy) acc++;
    end
    check_eq("abort_quiet", acc, 0);
  endtask

  initial begin
    for (int i = 0; i < MemWords; i++) mem[i] = DW'($urandom);
    rst        = 1'b1;
    start      = 1'b0;
    num_frames = '0;
    rd_base    = '0;
    wr_base    = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_strobes", {busy, done, rd_en, wr_en}, 4'b0000);
    check_eq("rst_rd_addr", rd_addr, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_wr_data", wr_data, 0);
    check_eq("rst_frame_idx", frame_idx, 0);
    rst = 1'b0;
    @(negedge clk);

    run_job(3, 12'h010, 12'h100, 0);
    run_job(0, 12'h020, 12'h200, 0);
    run_job(2, 12'hFFF, 12'hFFA, 0);
    run_job(4, 12'h040, 12'h400, 1);
    run_job(3, 12'h050, 12'h500, 2);
    run_abort();
    run_job(3, 12'h010, 12'h100, 0);

    mem[12'h200] = 16'hF830; // -2000
    mem[12'h201] = 16'd500;
    run_job(2, 12'h200, 12'h300, 0);

    for (int i = 0; i < 8; i++) begin
      run_job(int'($urandom_range(0, 6)), int'($urandom_range(0, MemWords - 1)),
              int'($urandom_range(0, MemWords - 1)), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
